// File: rtl/uart_rx_fifo.sv
// Receive FIFO between uart_rx and the CPU-polled uart_rx register.
// The head word falls through to dout, and rts_n is driven with hysteresis.
module uart_rx_fifo #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned HIGH_WM = 12,
  parameter int unsigned LOW_WM  = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          rcv,
  input  logic [7:0]    rx_data,
  input  logic          pop,
  input  logic          clr,
  output logic [15:0]   dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          rts_n
);

  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
  localparam logic [AW:0] HWM_C   = HIGH_WM[AW:0];
  localparam logic [AW:0] LWM_C   = LOW_WM[AW:0];

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic          r_rts_n;

  logic          w_pop;
  logic          w_push;
  logic [AW:0]   w_next_count;

  assign empty    = (r_count == '0);
  assign full     = (r_count == DEPTH_C);
  assign count    = r_count;
  assign overflow = r_overflow;
  assign rts_n    = r_rts_n;
  assign dout     = empty ? 16'hFFFF : {8'h00, r_mem[r_rd_ptr]};

  // A pop in the same cycle frees a slot, so a push at full is still accepted.
  assign w_pop  = pop && !empty;
  assign w_push = rcv && (!full || w_pop);

  always_comb begin
    w_next_count = r_count;
    if (w_push && !w_pop)
      w_next_count = r_count + 1'b1;
    else if (w_pop && !w_push)
      w_next_count = r_count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_push && !clr)
      r_mem[r_wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_rts_n    <= 1'b0;
    end else if (clr) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_rts_n    <= 1'b0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_next_count;
      if (rcv && !w_push)
        r_overflow <= 1'b1;
      // Between the watermarks rts_n keeps its previous value.
      if (w_next_count >= HWM_C)
        r_rts_n <= 1'b1;
      else if (w_next_count <= LWM_C)
        r_rts_n <= 1'b0;
    end
  end

endmodule
